instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch controller that sits directly downstream of the 32-bit PC register and consumes its output. It issues word-aligned read requests to instruction memory with a req/ack handshake. Returned instructions and their PCs are buffered in a small FIFO toward decode. It pulses pc_advance so the (enable-gated) PC register loads its next value only when a fetch actually completes, and it handles branch flush and misalignment.

Parameters:
DEPTH, 2, instruction FIFO entries; power of two, at least 2.
DATA_W, 32, instruction and PC width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset.
pcIn  input  DATA_W  current PC from the PC register.
flush  input  1  redirect (branch/jump taken): discard all buffered and in-flight fetches.
mem_req  output  1  read request to instruction memory.
mem_addr  output  DATA_W  request address, {pcIn[31:2],2'b00}.
mem_ack  input  1  memory accepts and returns data this cycle; only meaningful while mem_req=1.
mem_rdata  input  DATA_W  instruction word, valid when mem_ack=1.
pc_advance  output  1  one-cycle pulse; the PC register loads its next value at this clock edge.
inst_valid  output  1  FIFO head valid toward decode.
inst_ready  input  1  decode consumes head.
inst_out  output  DATA_W  head instruction.
inst_pc  output  DATA_W  PC of head instruction.
misalign  output  1  sticky: fetch attempted with pcIn[1:0]!=0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset, asynchronous and immediate:
  - State=IDLE; FIFO empty (count=0, pointers 0).
  - mem_req=0, pc_advance=0, inst_valid=0, misalign=0; inst_out/inst_pc=0.
  - Reset mid-request abandons the transaction. Memory must tolerate a dropped req.
- FSM states are IDLE, BUSY and DRAIN. mem_req=1 only in BUSY. mem_addr is combinational from pcIn.
- IDLE -> BUSY at the next edge when all of these hold: count<DEPTH, flush=0, misalign=0, pcIn[1:0]==0.
- IDLE with pcIn[1:0]!=0 and flush=0: set misalign. Stay IDLE. No request issued.
- misalign clears only on flush or rst.
- BUSY, mem_ack=1, flush=0:
  - Push {mem_rdata, pcIn} into the FIFO and assert pc_advance in the same cycle.
  - Stay BUSY if (count+1-pop)<DEPTH; otherwise go to IDLE.
  - Back-to-back acks give 1 instruction/cycle.
- BUSY, mem_ack=0: hold mem_req=1. mem_addr must stay stable, because PC does not advance.
- BUSY, flush=1:
  - With mem_ack=1 the data is discarded, pc_advance=0, next state IDLE.
  - With mem_ack=0, next state DRAIN.
- DRAIN: mem_req=0. Wait for memory to retire the abandoned request. The team's memory returns an ack for a dropped req at most once, within 1 cycle. Therefore DRAIN -> IDLE unconditionally after 1 cycle, discarding any mem_rdata.
- flush in any state:
  - FIFO cleared at the edge; inst_valid=0 the next cycle.
  - Simultaneous pop is ignored.
  - Flush has priority over push.
  - pc_advance is never asserted in a flush cycle.
- FIFO rules:
  - inst_valid = count!=0. Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Push when full cannot occur, because space is checked before issue. Treat it as an assertion failure.
  - Pointers wrap modulo DEPTH.
  - Head data is registered; inst_out/inst_pc hold stable while inst_valid && !inst_ready.
- Latency: pcIn valid in IDLE -> mem_req the next cycle -> with a same-cycle ack, inst_valid the following cycle (2 cycles from IDLE to decode).

Test Plan:
1. rst, pcIn=0x0000_0000, mem_ack tied 1, inst_ready=1, PC+4 on pc_advance -> inst_pc sequence 0x0,0x4,0x8,… one per cycle after the first; inst_out=mem_rdata per address.
2. inst_ready=0, mem_ack=1 -> exactly DEPTH=2 pushes, then mem_req=0, pc_advance silent; raise inst_ready -> fetching resumes with no lost or duplicated PC.
3. mem_ack delayed 3 cycles at pcIn=0x100 -> mem_req and mem_addr=0x100 held 3 cycles, single pc_advance on the ack cycle.
4. flush in BUSY with mem_ack=0 -> DRAIN for 1 cycle, a late ack is ignored, FIFO empty, no pc_advance; the next fetch uses the redirected pcIn=0x200.
5. pcIn=0x102 in IDLE -> misalign=1, mem_req stays 0; flush with pcIn=0x104 -> misalign=0, fetch 0x104.
6. rst asserted mid-BUSY with 1 FIFO entry -> mem_req, inst_valid, pc_advance = 0 immediately (before the next clk edge).

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus bundle: PC input, redirect, instruction-memory handshake and decode-side FIFO
// head. master = fetch controller, slave = the surrounding pipeline/memory.
interface instr_fetch_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] pcIn;
  logic              flush;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              pc_advance;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_out;
  logic [DATA_W-1:0] inst_pc;
  logic              misalign;

  modport master (
    input  pcIn, flush, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, pc_advance, inst_valid, inst_out, inst_pc, misalign
  );

  modport slave (
    output pcIn, flush, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, pc_advance, inst_valid, inst_out, inst_pc, misalign
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues word-aligned reads for the current PC, buffers returned
// instructions with their PCs in a small FIFO and pulses pc_advance on each completed fetch.
module instr_fetch_ctrl #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_ctrl_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} stateT;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   countQ, countD;
  logic [PtrW-1:0]   wrPtrQ, rdPtrQ;
  logic [DATA_W-1:0] instMemQ [DEPTH];
  logic [DATA_W-1:0] pcMemQ   [DEPTH];
  logic              misalignQ, misalignD;
  logic              push, pop;

  // Flush wins over both push and pop.
  always_comb begin
    push   = (stateQ == StBusy) && bus.mem_ack && !bus.flush;
    pop    = (countQ != '0) && bus.inst_ready && !bus.flush;
    countD = countQ;
    if (bus.flush) begin
      countD = '0;
    end else begin
      countD = countQ + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
    end
  end

  // Next-state logic.
  always_comb begin
    stateD    = stateQ;
    misalignD = misalignQ;
    if (bus.flush) begin
      misalignD = 1'b0;
    end
    unique case (stateQ)
      StIdle: begin
        if (!bus.flush) begin
          if (bus.pcIn[1:0] != 2'b00) begin
            misalignD = 1'b1;
          end else if (!misalignQ && (countQ < DepthCnt)) begin
            stateD = StBusy;
          end
        end
      end
      StBusy: begin
        if (bus.flush) begin
          // An unacked request is still outstanding and must be retired in DRAIN.
          stateD = bus.mem_ack ? StIdle : StDrain;
        end else if (bus.mem_ack) begin
          stateD = (countD < DepthCnt) ? StBusy : StIdle;
        end
      end
      StDrain: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= StIdle;
      misalignQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      misalignQ <= misalignD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ <= '0;
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      countQ <= countD;
      if (bus.flush) begin
        wrPtrQ <= '0;
        rdPtrQ <= '0;
      end else begin
        if (push) begin
          wrPtrQ <= wrPtrQ + 1'b1;
        end
        if (pop) begin
          rdPtrQ <= rdPtrQ + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instMemQ[i] <= '0;
        pcMemQ[i]   <= '0;
      end
    end else if (push) begin
      instMemQ[wrPtrQ] <= bus.mem_rdata;
      pcMemQ[wrPtrQ]   <= bus.pcIn;
    end
  end

  always_comb begin
    bus.mem_req    = (stateQ == StBusy);
    bus.mem_addr   = {bus.pcIn[DATA_W-1:2], 2'b00};
    bus.pc_advance = push;
    bus.inst_valid = (countQ != '0);
    bus.inst_out   = instMemQ[rdPtrQ];
    bus.inst_pc    = pcMemQ[rdPtrQ];
    bus.misalign   = misalignQ;
  end

  // Space is checked before issue, so a push into a full FIFO is a design bug.
  pushNotFull: assert property (@(posedge clk) disable iff (rst) push |-> (countQ < DepthCnt));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: per-cycle vector table plus hand-written sequences for
// streaming, back-pressure and asynchronous reset.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] Key = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic useModel = 1'b0;
  logic [31:0] rowRdata = '0;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.DATA_W(32)) bus ();

  instr_fetch_ctrl #(.DEPTH(2), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory model: word returned is address XOR Key unless a table row forces a value.
  assign bus.mem_rdata = useModel ? (bus.mem_addr ^ Key) : rowRdata;

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        adv;
    logic        valid;
    logic [31:0] iout;
    logic [31:0] ipc;
    logic        mis;
  } vecT;

  typedef struct packed {
    logic        ready;
    logic        req;
    logic        adv;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
  } seqT;

  vecT vecs [22];
  seqT bp [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    logic adv;
    bus.pcIn       = '0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.inst_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[1]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[2]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{1'b0, 32'h100, 1'b0, 1'b1, 32'hDEAD0100, 1'b1,
                 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[6]  = '{1'b0, 32'h104, 1'b0, 1'b0, 32'h0,        1'b0,
                 1'b1, 32'h104, 1'b0, 1'b1, 32'hDEAD0100, 32'h100, 1'b0};
    vecs[7]  = '{1'b0, 32'h104, 1'b1, 1'b0, 32'h0,        1'b1,
                 1'b1, 32'h104, 1'b0, 1'b1, 32'hDEAD0100, 32'h100, 1'b0};
    vecs[8]  = '{1'b0, 32'h200, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b1,
                 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[9]  = '{1'b0, 32'h200, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[10] = '{1'b0, 32'h200, 1'b0, 1'b1, 32'h0200AAAA, 1'b1,
                 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[11] = '{1'b0, 32'h204, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b1, 32'h204, 1'b0, 1'b1, 32'h0200AAAA, 32'h200, 1'b0};
    vecs[12] = '{1'b0, 32'h204, 1'b1, 1'b0, 32'h0,        1'b1,
                 1'b1, 32'h204, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[13] = '{1'b0, 32'h102, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[14] = vecs[13];
    vecs[15] = '{1'b0, 32'h102, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,   1'b1};
    vecs[16] = '{1'b0, 32'h104, 1'b1, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,        32'h0,   1'b1};
    vecs[17] = '{1'b0, 32'h104, 1'b0, 1'b0, 32'h0,        1'b1,
                 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[18] = '{1'b0, 32'h104, 1'b0, 1'b1, 32'h0104BEEF, 1'b0,
                 1'b1, 32'h104, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[19] = '{1'b0, 32'h108, 1'b1, 1'b1, 32'hBAD0BAD0, 1'b0,
                 1'b1, 32'h108, 1'b0, 1'b1, 32'h0104BEEF, 32'h104, 1'b0};
    vecs[20] = '{1'b0, 32'h108, 1'b0, 1'b0, 32'h0,        1'b0,
                 1'b0, 32'h108, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};
    vecs[21] = '{1'b0, 32'h108, 1'b0, 1'b0, 32'h0,        1'b0,
                 1'b1, 32'h108, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0};

    // Back-pressure: two pushes fill the FIFO, fetch stalls, then resumes at PC 8.
    bp[0] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    bp[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    bp[2] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
    bp[3] = '{1'b0, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
    bp[4] = '{1'b0, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
    bp[5] = '{1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
    bp[6] = '{1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h4};
    bp[7] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0};
    bp[8] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8};

    // Reset state.
    #3;
    chk("reset mem_req", 32'(bus.mem_req), 32'h0);
    chk("reset pc_advance", 32'(bus.pc_advance), 32'h0);
    chk("reset inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("reset misalign", 32'(bus.misalign), 32'h0);
    chk("reset inst_out", bus.inst_out, 32'h0);
    chk("reset inst_pc", bus.inst_pc, 32'h0);
    nextCycle();

    // Table: one row per cycle, inputs applied after the edge, outputs checked mid-cycle.
    for (int i = 0; i < 22; i++) begin
      rst            = vecs[i].rst;
      bus.pcIn       = vecs[i].pc;
      bus.flush      = vecs[i].flush;
      bus.mem_ack    = vecs[i].ack;
      rowRdata       = vecs[i].rdata;
      bus.inst_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].req));
      chk($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].addr);
      chk($sformatf("row%0d pc_advance", i), 32'(bus.pc_advance), 32'(vecs[i].adv));
      chk($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].valid));
      chk($sformatf("row%0d misalign", i), 32'(bus.misalign), 32'(vecs[i].mis));
      if (vecs[i].valid) begin
        chk($sformatf("row%0d inst_out", i), bus.inst_out, vecs[i].iout);
        chk($sformatf("row%0d inst_pc", i), bus.inst_pc, vecs[i].ipc);
      end
      nextCycle();
    end
    bus.flush = 1'b0;

    // Streaming with ack tied high: one instruction per cycle after the first.
    useModel       = 1'b1;
    bus.pcIn       = '0;
    bus.mem_ack    = 1'b1;
    bus.inst_ready = 1'b1;
    doReset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d mem_req", k), 32'(bus.mem_req), (k == 0) ? 32'h0 : 32'h1);
      chk($sformatf("stream%0d pc_advance", k), 32'(bus.pc_advance), (k == 0) ? 32'h0 : 32'h1);
      chk($sformatf("stream%0d inst_valid", k), 32'(bus.inst_valid), (k < 2) ? 32'h0 : 32'h1);
      if (k >= 1) begin
        chk($sformatf("stream%0d mem_addr", k), bus.mem_addr, 32'(4 * (k - 1)));
      end
      if (k >= 2) begin
        chk($sformatf("stream%0d inst_pc", k), bus.inst_pc, 32'(4 * (k - 2)));
        chk($sformatf("stream%0d inst_out", k), bus.inst_out, 32'(4 * (k - 2)) ^ Key);
      end
      adv = bus.pc_advance;
      nextCycle();
      if (adv) bus.pcIn = bus.pcIn + 32'd4;
    end

    // Back-pressure sequence.
    bus.pcIn       = '0;
    bus.inst_ready = 1'b0;
    doReset();
    for (int k = 0; k < 9; k++) begin
      bus.inst_ready = bp[k].ready;
      @(negedge clk);
      chk($sformatf("bp%0d mem_req", k), 32'(bus.mem_req), 32'(bp[k].req));
      chk($sformatf("bp%0d pc_advance", k), 32'(bus.pc_advance), 32'(bp[k].adv));
      chk($sformatf("bp%0d mem_addr", k), bus.mem_addr, bp[k].addr);
      chk($sformatf("bp%0d inst_valid", k), 32'(bus.inst_valid), 32'(bp[k].valid));
      if (bp[k].valid) begin
        chk($sformatf("bp%0d inst_pc", k), bus.inst_pc, bp[k].ipc);
        chk($sformatf("bp%0d inst_out", k), bus.inst_out, bp[k].ipc ^ Key);
      end
      adv = bus.pc_advance;
      nextCycle();
      if (adv) bus.pcIn = bus.pcIn + 32'd4;
    end

    // Asynchronous reset in BUSY with one FIFO entry: outputs drop before the next edge.
    bus.pcIn       = '0;
    bus.inst_ready = 1'b0;
    doReset();
    nextCycle();
    nextCycle();
    bus.pcIn = 32'h4;
    #2;
    chk("prerst mem_req", 32'(bus.mem_req), 32'h1);
    chk("prerst inst_valid", 32'(bus.inst_valid), 32'h1);
    chk("prerst pc_advance", 32'(bus.pc_advance), 32'h1);
    rst = 1'b1;
    #1;
    chk("asyncrst mem_req", 32'(bus.mem_req), 32'h0);
    chk("asyncrst inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("asyncrst pc_advance", 32'(bus.pc_advance), 32'h0);
    chk("asyncrst inst_out", bus.inst_out, 32'h0);
    chk("asyncrst inst_pc", bus.inst_pc, 32'h0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
